// File: rtl/zvc_line_packer.sv
// Repacks variable-length compressed lines into dense LINE_SIZE-entry output lines.
// A 2*LINE_SIZE entry buffer absorbs one partial line plus one incoming line.
module zvc_line_packer #(
  parameter int unsigned WORD_WIDTH    = 8,
  parameter int unsigned LINE_SIZE     = 32,
  parameter int unsigned DIST_WIDTH    = 7,
  parameter int unsigned MAX_LIFM_RSIZ = 3
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0]                 in_word,
  input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]   in_mt,
  input  logic [$clog2(LINE_SIZE):0]                      in_cnt,
  input  logic                                            in_last,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [LINE_SIZE*WORD_WIDTH-1:0]                 out_word,
  output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]   out_mt,
  output logic [$clog2(LINE_SIZE):0]                      out_cnt,
  output logic                                            out_last
);

  localparam int unsigned MT_WIDTH = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int unsigned CNT_W    = $clog2(LINE_SIZE) + 1;
  localparam int unsigned LVL_W    = $clog2(LINE_SIZE) + 2;
  localparam int unsigned IDX_W    = $clog2(LINE_SIZE);
  localparam int unsigned BUF_N    = 2 * LINE_SIZE;
  localparam int unsigned BUF_IW   = $clog2(BUF_N);

  logic [WORD_WIDTH-1:0] word_q [BUF_N];
  logic [WORD_WIDTH-1:0] word_d [BUF_N];
  logic [MT_WIDTH-1:0]   mt_q   [BUF_N];
  logic [MT_WIDTH-1:0]   mt_d   [BUF_N];
  logic [LVL_W-1:0]      lvl_q, lvl_d;
  logic                  flush_q, flush_d;

  logic [WORD_WIDTH-1:0] in_w [LINE_SIZE];
  logic [MT_WIDTH-1:0]   in_m [LINE_SIZE];

  logic                  in_fire, out_fire, lvl_full;
  logic [CNT_W-1:0]      eff_cnt;
  logic [LVL_W-1:0]      shift, base;

  for (genvar g = 0; g < LINE_SIZE; g++) begin : g_lane
    assign in_w[g] = in_word[g*WORD_WIDTH +: WORD_WIDTH];
    assign in_m[g] = in_mt[g*MT_WIDTH +: MT_WIDTH];
    // Entries at or above lvl are always zero, so no masking is needed here.
    assign out_word[g*WORD_WIDTH +: WORD_WIDTH] = word_q[g];
    assign out_mt[g*MT_WIDTH +: MT_WIDTH]       = mt_q[g];
  end

  assign lvl_full  = (lvl_q >= LVL_W'(LINE_SIZE));
  assign out_valid = lvl_full | flush_q;
  assign out_cnt   = lvl_full ? CNT_W'(LINE_SIZE) : lvl_q[CNT_W-1:0];
  assign out_last  = flush_q & (lvl_q <= LVL_W'(LINE_SIZE));
  assign in_ready  = ~flush_q & (~lvl_full | out_ready);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign eff_cnt  = (in_cnt > CNT_W'(LINE_SIZE)) ? CNT_W'(LINE_SIZE) : in_cnt;
  assign shift    = out_fire ? LVL_W'(out_cnt) : '0;
  assign base     = lvl_q - shift;

  always_comb begin
    for (int unsigned i = 0; i < BUF_N; i++) begin
      word_d[i] = '0;
      mt_d[i]   = '0;
      if (i + 32'(shift) < BUF_N) begin
        word_d[i] = word_q[BUF_IW'(i + 32'(shift))];
        mt_d[i]   = mt_q[BUF_IW'(i + 32'(shift))];
      end
      if (in_fire && (i >= 32'(base)) && (i < 32'(base) + 32'(eff_cnt))) begin
        word_d[i] = in_w[IDX_W'(i - 32'(base))];
        mt_d[i]   = in_m[IDX_W'(i - 32'(base))];
      end
    end
    lvl_d = lvl_q - shift + (in_fire ? LVL_W'(eff_cnt) : '0);
    // in_ready is low while flushing, so set and clear never coincide.
    flush_d = flush_q;
    if (out_fire && out_last) flush_d = 1'b0;
    if (in_fire && in_last)   flush_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < BUF_N; i++) begin
        word_q[i] <= '0;
        mt_q[i]   <= '0;
      end
      lvl_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < BUF_N; i++) begin
        word_q[i] <= word_d[i];
        mt_q[i]   <= mt_d[i];
      end
      lvl_q   <= lvl_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_zvc_line_packer.sv
// Bench for zvc_line_packer: queue-based reference model checked every cycle,
// a table of two-line flush scenarios, hand-written corner sequences and random traffic.
module tb_zvc_line_packer;

  localparam int LS = 32;
  localparam int WW = 8;
  localparam int MW = 21;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LS*WW-1:0]  in_word = '0;
  logic [LS*MW-1:0]  in_mt = '0;
  logic [5:0]        in_cnt = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LS*WW-1:0]  out_word;
  logic [LS*MW-1:0]  out_mt;
  logic [5:0]        out_cnt;
  logic              out_last;

  zvc_line_packer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .in_mt    (in_mt),
    .in_cnt   (in_cnt),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_mt   (out_mt),
    .out_cnt  (out_cnt),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] w;
    logic [MW-1:0] m;
  } ent_t;

  typedef struct {
    int cnt_a;
    int cnt_b;
    int n_out;
    int c0;
    bit l0;
    int c1;
    bit l1;
  } vec_t;

  ent_t mq[$];
  bit   mflush;
  bit   last_in_fire, last_out_fire;
  int   cap_cnt[$];
  bit   cap_last[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic void chk(input string nm, input logic [1023:0] got,
                              input logic [1023:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h", nm, got, exp);
  endfunction

  // Compare DUT against the model at negedge, then advance the model on the posedge.
  task automatic cyc();
    int sz, ec, n;
    bit ev, el, er, fi, fo;
    logic [LS*WW-1:0] ew;
    logic [LS*MW-1:0] em;
    ent_t e;
    @(negedge clk);
    sz = mq.size();
    ec = (sz < LS) ? sz : LS;
    ev = (sz >= LS) || mflush;
    el = mflush && (sz <= LS);
    er = !mflush && ((sz < LS) || out_ready);
    ew = '0;
    em = '0;
    for (int j = 0; j < ec; j++) begin
      ew[j*WW +: WW] = mq[j].w;
      em[j*MW +: MW] = mq[j].m;
    end
    chk("out_valid", 1024'(out_valid), 1024'(ev));
    chk("in_ready", 1024'(in_ready), 1024'(er));
    chk("out_cnt", 1024'(out_cnt), 1024'(ec));
    chk("out_last", 1024'(out_last), 1024'(el));
    chk("out_word", 1024'(out_word), 1024'(ew));
    chk("out_mt", 1024'(out_mt), 1024'(em));
    fi = in_valid && er;
    fo = ev && out_ready;
    if (fo) begin
      cap_cnt.push_back(int'(out_cnt));
      cap_last.push_back(out_last);
    end
    @(posedge clk);
    if (fo) begin
      repeat (ec) void'(mq.pop_front());
      if (el) mflush = 1'b0;
    end
    if (fi) begin
      n = (int'(in_cnt) > LS) ? LS : int'(in_cnt);
      for (int k = 0; k < n; k++) begin
        e.w = in_word[k*WW +: WW];
        e.m = in_mt[k*MW +: MW];
        mq.push_back(e);
      end
      if (in_last) mflush = 1'b1;
    end
    last_in_fire  = fi;
    last_out_fire = fo;
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < LS; k++) begin
      in_word[k*WW +: WW] = WW'($urandom);
      in_mt[k*MW +: MW]   = MW'($urandom);
    end
  endtask

  task automatic send_line(input int cnt, input bit last);
    bit ok;
    rand_data();
    in_cnt   = 6'(cnt);
    in_last  = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      cyc();
      ok = last_in_fire;
    end
    chk("send_accept", 1024'(ok), 1024'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && (mq.size() != 0 || mflush); t++) cyc();
    chk("drain_done", 1024'(mq.size() != 0 || mflush), 1024'(0));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("rst_valid", 1024'(out_valid), 1024'(0));
    chk("rst_ready", 1024'(in_ready), 1024'(1));
    chk("rst_cnt", 1024'(out_cnt), 1024'(0));
    chk("rst_last", 1024'(out_last), 1024'(0));
    chk("rst_word", 1024'(out_word), 1024'(0));
    chk("rst_mt", 1024'(out_mt), 1024'(0));
    mq.delete();
    mflush = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{cnt_a: 20, cnt_b: 20, n_out: 2, c0: 32, l0: 0, c1: 8,  l1: 1};
    tbl[1] = '{cnt_a: 5,  cnt_b: 10, n_out: 1, c0: 15, l0: 1, c1: 0,  l1: 0};
    tbl[2] = '{cnt_a: 0,  cnt_b: 0,  n_out: 1, c0: 0,  l0: 1, c1: 0,  l1: 0};
    tbl[3] = '{cnt_a: 30, cnt_b: 32, n_out: 2, c0: 32, l0: 0, c1: 30, l1: 1};
    tbl[4] = '{cnt_a: 20, cnt_b: 45, n_out: 2, c0: 32, l0: 0, c1: 20, l1: 1};
    tbl[5] = '{cnt_a: 31, cnt_b: 32, n_out: 2, c0: 32, l0: 0, c1: 31, l1: 1};
    tbl[6] = '{cnt_a: 0,  cnt_b: 63, n_out: 1, c0: 32, l0: 1, c1: 0,  l1: 0};

    #2;
    do_reset();

    // Two lines with the consumer stalled, then drain the flush.
    foreach (tbl[r]) begin
      do_reset();
      out_ready = 1'b0;
      send_line(tbl[r].cnt_a, 1'b0);
      send_line(tbl[r].cnt_b, 1'b1);
      cap_cnt.delete();
      cap_last.delete();
      out_ready = 1'b1;
      drain();
      cyc();
      chk("tbl_nout", 1024'(cap_cnt.size()), 1024'(tbl[r].n_out));
      if (cap_cnt.size() > 0) begin
        chk("tbl_cnt0", 1024'(cap_cnt[0]), 1024'(tbl[r].c0));
        chk("tbl_last0", 1024'(cap_last[0]), 1024'(tbl[r].l0));
      end
      if (cap_cnt.size() > 1) begin
        chk("tbl_cnt1", 1024'(cap_cnt[1]), 1024'(tbl[r].c1));
        chk("tbl_last1", 1024'(cap_last[1]), 1024'(tbl[r].l1));
      end
    end

    // 20 + 20 with consumer ready: one full line, 8 left over.
    do_reset();
    out_ready = 1'b1;
    cap_cnt.delete();
    send_line(20, 1'b0);
    send_line(20, 1'b0);
    cyc();
    chk("two20_fires", 1024'(cap_cnt.size()), 1024'(1));
    if (cap_cnt.size() > 0) chk("two20_cnt", 1024'(cap_cnt[0]), 1024'(32));
    chk("two20_left", 1024'(out_cnt), 1024'(8));
    chk("two20_idle", 1024'(out_valid), 1024'(0));

    // Level 31 plus a full line, then concurrent accept and emit at level 63.
    do_reset();
    out_ready = 1'b1;
    send_line(31, 1'b0);
    send_line(32, 1'b0);
    chk("l63_valid", 1024'(out_valid), 1024'(1));
    cap_cnt.delete();
    send_line(32, 1'b0);
    chk("both_fire", 1024'(cap_cnt.size()), 1024'(1));
    cyc();
    cyc();
    chk("after_both_cnt", 1024'(out_cnt), 1024'(31));

    // Level 5 plus 10 with last: one 15-entry final line.
    do_reset();
    out_ready = 1'b0;
    send_line(5, 1'b0);
    send_line(10, 1'b1);
    cyc();
    chk("f15_cnt", 1024'(out_cnt), 1024'(15));
    chk("f15_last", 1024'(out_last), 1024'(1));
    chk("f15_ready", 1024'(in_ready), 1024'(0));
    out_ready = 1'b1;
    cyc();
    chk("f15_after_ready", 1024'(in_ready), 1024'(1));
    chk("f15_after_valid", 1024'(out_valid), 1024'(0));

    // Long stall at level 40.
    do_reset();
    out_ready = 1'b0;
    send_line(20, 1'b0);
    send_line(20, 1'b0);
    repeat (10) begin
      cyc();
      chk("stall_valid", 1024'(out_valid), 1024'(1));
      chk("stall_ready", 1024'(in_ready), 1024'(0));
    end
    out_ready = 1'b1;
    cap_cnt.delete();
    cyc();
    if (cap_cnt.size() > 0) chk("stall_rel_cnt", 1024'(cap_cnt[0]), 1024'(32));
    else chk("stall_rel_fire", 1024'(0), 1024'(1));
    chk("stall_left", 1024'(out_cnt), 1024'(8));

    // Reset while 17 entries and a flush are pending.
    do_reset();
    out_ready = 1'b0;
    send_line(17, 1'b1);
    cyc();
    chk("pre_rst_last", 1024'(out_last), 1024'(1));
    do_reset();
    out_ready = 1'b1;
    send_line(32, 1'b0);
    cap_cnt.delete();
    cyc();
    if (cap_cnt.size() > 0) chk("post_rst_cnt", 1024'(cap_cnt[0]), 1024'(32));
    else chk("post_rst_fire", 1024'(0), 1024'(1));

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_data();
      in_valid  = ($urandom % 3) != 0;
      in_cnt    = 6'($urandom_range(0, 40));
      in_last   = ($urandom % 10) == 0;
      out_ready = ($urandom % 4) != 0;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
